// File: rtl/vrc7_pkg.sv
// Shared constants and types for the VRC7 register port: bus decode values,
// register-space limit, issue FSM states and the queued write entry.
package vrc7_pkg;

  localparam logic [15:0] PORT_MASK = 16'hF030;
  localparam logic [15:0] PORT_ADDR = 16'h9010;
  localparam logic [15:0] PORT_DATA = 16'h9030;
  localparam logic [7:0]  REG_LIMIT = 8'h40;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } issue_state_t;

  typedef struct packed {
    logic [5:0] idx;
    logic [7:0] dat;
  } fifo_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Small single-clock FIFO. A push is refused when full, judged on the
// occupancy before any same-cycle pop; flush empties it in one cycle.
module sync_fifo #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full & ~flush;
  assign do_pop   = pop & ~empty & ~flush;
  assign pop_data = mem[rd_ptr];

  // Storage array; contents are don't-care while the pointers say empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/vrc7_reg_port.sv
// VRC7 audio register port: decodes $9010/$9030 CPU writes, queues completed
// register writes, keeps a shadow copy, and paces issue to the OPLL core.
module vrc7_reg_port
  import vrc7_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int WAIT_CYC   = 42
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        map_en,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dat,
  input  logic        snd_rst,
  output logic        opl_req,
  output logic [5:0]  opl_addr,
  output logic [7:0]  opl_dat,
  input  logic        opl_ack,
  input  logic [5:0]  ss_idx,
  output logic [7:0]  ss_dout,
  output logic        ovf
);

  localparam logic [7:0] WAIT_INIT = 8'(WAIT_CYC - 1);

  issue_state_t state;
  logic [7:0]   cnt;
  logic [5:0]   reg_latch;
  logic         latch_ok;
  logic [7:0]   shadow [64];

  logic        wr_addr;
  logic        wr_data;
  logic        push_req;
  logic        push_ok;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_pop;
  fifo_entry_t push_entry;
  fifo_entry_t head;

  // CPU writes are ignored entirely while the sound reset is held.
  assign wr_addr  = cpu_we & map_en & ~snd_rst & ((cpu_addr & PORT_MASK) == PORT_ADDR);
  assign wr_data  = cpu_we & map_en & ~snd_rst & ((cpu_addr & PORT_MASK) == PORT_DATA);
  assign push_req = wr_data & latch_ok;
  assign push_ok  = push_req & ~fifo_full;
  assign fifo_pop = (state == ST_IDLE) & ~fifo_empty & ~snd_rst;

  assign push_entry.idx = reg_latch;
  assign push_entry.dat = cpu_dat;

  sync_fifo #(
    .WIDTH ($bits(fifo_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (snd_rst),
    .push      (push_req),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Register-index latch; indices beyond the 64-register space disarm data writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_latch <= '0;
      latch_ok  <= 1'b0;
    end else if (snd_rst) begin
      reg_latch <= '0;
      latch_ok  <= 1'b0;
    end else if (wr_addr) begin
      reg_latch <= cpu_dat[5:0];
      latch_ok  <= (cpu_dat < REG_LIMIT);
    end
  end

  // Sticky overflow flag: set when a valid data write finds the queue full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     ovf <= 1'b0;
    else if (snd_rst)               ovf <= 1'b0;
    else if (push_req && fifo_full) ovf <= 1'b0 | 1'b1;
  end

  // Shadow registers track accepted writes, not issued ones.
  for (genvar gi = 0; gi < 64; gi++) begin : g_shadow
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                   shadow[gi] <= '0;
      else if (snd_rst)                             shadow[gi] <= '0;
      else if (push_ok && (reg_latch == 6'(gi)))    shadow[gi] <= cpu_dat;
    end
  end

  assign ss_dout = shadow[ss_idx];

  // Issue FSM: pop into registered outputs, hold until ack, then recovery gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      opl_req  <= 1'b0;
      opl_addr <= '0;
      opl_dat  <= '0;
    end else if (snd_rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      opl_req <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            opl_addr <= head.idx;
            opl_dat  <= head.dat;
            opl_req  <= 1'b1;
            state    <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (opl_ack) begin
            opl_req <= 1'b0;
            cnt     <= WAIT_INIT;
            state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt == '0) state <= ST_IDLE;
          else           cnt   <= cnt - 8'd1;
        end
        default: begin
          state   <= ST_IDLE;
          opl_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vrc7_reg_port.sv
// Directed bench for vrc7_reg_port: latency, pacing, overflow, latch range,
// sound reset and asynchronous reset, all against hand-computed values.
module tb_vrc7_reg_port;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        map_en;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dat;
  logic        snd_rst;
  logic        opl_req;
  logic [5:0]  opl_addr;
  logic [7:0]  opl_dat;
  logic        opl_ack;
  logic [5:0]  ss_idx;
  logic [7:0]  ss_dout;
  logic        ovf;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  vrc7_reg_port #(.FIFO_DEPTH(4), .WAIT_CYC(42)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .map_en   (map_en),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_dat  (cpu_dat),
    .snd_rst  (snd_rst),
    .opl_req  (opl_req),
    .opl_addr (opl_addr),
    .opl_dat  (opl_dat),
    .opl_ack  (opl_ack),
    .ss_idx   (ss_idx),
    .ss_dout  (ss_dout),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // One CPU write strobe; called and returns on a falling edge.
  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    cpu_we   = 1'b1;
    cpu_addr = a;
    cpu_dat  = d;
    @(negedge clk);
    cpu_we   = 1'b0;
  endtask

  task automatic shadow_is(input string tag, input logic [5:0] idx, input logic [7:0] exp);
    ss_idx = idx;
    #1;
    chk(tag, 32'(ss_dout), 32'(exp));
  endtask

  task automatic wait_req(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (opl_req) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Ack one clock after the request was first seen.
  task automatic give_ack();
    @(negedge clk);
    opl_ack = 1'b1;
    @(negedge clk);
    opl_ack = 1'b0;
  endtask

  task automatic no_req_for(input string tag, input int n);
    int hits = 0;
    repeat (n) begin
      @(negedge clk);
      if (opl_req) hits++;
    end
    chk(tag, 32'(hits), 0);
  endtask

  initial begin
    bit ok;
    int t_rise [3];
    logic [7:0] pdat [3];

    rst_n = 1'b0; map_en = 1'b1; cpu_we = 1'b0; cpu_addr = '0; cpu_dat = '0;
    snd_rst = 1'b0; opl_ack = 1'b0; ss_idx = '0;
    repeat (2) @(negedge clk);
    chk("rst_req",  32'(opl_req),  0);
    chk("rst_addr", 32'(opl_addr), 0);
    chk("rst_dat",  32'(opl_dat),  0);
    chk("rst_ovf",  32'(ovf),      0);
    shadow_is("rst_shadow", 6'h10, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single write: request two clocks after the data strobe.
    cpu_write(16'h9010, 8'h10);
    cpu_write(16'h9030, 8'hA5);
    chk("single_req_n1", 32'(opl_req), 0);
    @(negedge clk);
    chk("single_req_n2", 32'(opl_req),  1);
    chk("single_addr",   32'(opl_addr), 'h10);
    chk("single_dat",    32'(opl_dat),  'hA5);
    give_ack();
    chk("single_req_drop", 32'(opl_req), 0);
    shadow_is("single_shadow", 6'h10, 8'hA5);

    // Out-of-range latch and map_en low: neither may queue anything.
    cpu_write(16'h9010, 8'h45);
    cpu_write(16'h9030, 8'h77);
    cpu_write(16'h9010, 8'h11);
    map_en = 1'b0;
    cpu_write(16'h9030, 8'h33);
    map_en = 1'b1;
    no_req_for("oor_no_req", 60);
    shadow_is("oor_shadow", 6'h05, 8'h00);
    shadow_is("mapen_shadow", 6'h11, 8'h00);
    chk("oor_ovf", 32'(ovf), 0);

    // Pacing: three queued writes, rising edges 45 clocks apart, in order.
    pdat[0] = 8'h11; pdat[1] = 8'h22; pdat[2] = 8'h33;
    for (int k = 0; k < 3; k++) begin
      cpu_write(16'h9010, 8'(k + 1));
      cpu_write(16'h9030, pdat[k]);
    end
    for (int k = 0; k < 3; k++) begin
      wait_req(200, ok);
      if (!ok) chk("pace_timeout", 0, 1);
      t_rise[k] = cyc;
      chk($sformatf("pace_addr%0d", k), 32'(opl_addr), 32'(k + 1));
      chk($sformatf("pace_dat%0d", k),  32'(opl_dat),  32'(pdat[k]));
      give_ack();
    end
    chk("pace_gap1", 32'(t_rise[1] - t_rise[0]), 45);
    chk("pace_gap2", 32'(t_rise[2] - t_rise[1]), 45);
    repeat (50) @(negedge clk);

    // Overflow: ack held low, six writes to register 5; the sixth is dropped.
    cpu_write(16'h9010, 8'h05);
    for (int k = 0; k < 6; k++) begin
      cpu_write(16'h9030, 8'(8'hA1 + k));
      if (k == 4) chk("ovf_before6", 32'(ovf), 0);
    end
    chk("ovf_set",     32'(ovf),      1);
    chk("ovf_req",     32'(opl_req),  1);
    chk("ovf_head",    32'(opl_dat),  'hA1);
    shadow_is("ovf_shadow", 6'h05, 8'hA5);

    // Sound reset during REQ with entries queued.
    snd_rst = 1'b1;
    @(negedge clk);
    snd_rst = 1'b0;
    chk("srst_req", 32'(opl_req), 0);
    chk("srst_ovf", 32'(ovf),     0);
    shadow_is("srst_shadow5",  6'h05, 8'h00);
    shadow_is("srst_shadow10", 6'h10, 8'h00);
    opl_ack = 1'b1;
    @(negedge clk);
    opl_ack = 1'b0;
    cpu_write(16'h9030, 8'h99);
    no_req_for("srst_no_req", 60);
    shadow_is("srst_latch_clr", 6'h00, 8'h00);

    // Asynchronous reset in the middle of the recovery gap.
    cpu_write(16'h9010, 8'h2A);
    cpu_write(16'h9030, 8'h5C);
    wait_req(10, ok);
    if (!ok) chk("arst_setup_timeout", 0, 1);
    give_ack();
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req",  32'(opl_req),  0);
    chk("arst_addr", 32'(opl_addr), 0);
    chk("arst_dat",  32'(opl_dat),  0);
    shadow_is("arst_shadow", 6'h2A, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cpu_write(16'h9010, 8'h3F);
    cpu_write(16'h9030, 8'hC3);
    chk("arst_post_n1", 32'(opl_req), 0);
    @(negedge clk);
    chk("arst_post_n2",   32'(opl_req),  1);
    chk("arst_post_addr", 32'(opl_addr), 'h3F);
    chk("arst_post_dat",  32'(opl_dat),  'hC3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
